// File: rtl/subtractor_tree_pipelined.sv
// subtractor_tree_pipelined
//   Two-stage streaming subtractor tree.
//   Stage 1 registers diff1 = a - b and diff2 = c - d (zero-extended operands).
//   Stage 2 (the output registers) adds diff3 = diff1 - diff2 and the sign bits.
//   Both ends use valid/ready handshakes; throughput is one result per cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for operand set a, b, c, d
//   a, b   [AW-1:0]      unsigned operands of diff1
//   c, d   [CW-1:0]      unsigned operands of diff2
//   out_valid/out_ready  output handshake
//   diff1  [AW:0]        signed a - b
//   diff2  [CW:0]        signed c - d
//   diff3  [CW+1:0]      signed diff1 - diff2
//   neg    [2:0]         {diff3<0, diff2<0, diff1<0}
//   result_count         output handshakes delivered, wraps modulo 2^CNTW
module subtractor_tree_pipelined #(
  parameter int AW   = 4,
  parameter int CW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   a,
  input  logic [AW-1:0]   b,
  input  logic [CW-1:0]   c,
  input  logic [CW-1:0]   d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW:0]     diff1,
  output logic [CW:0]     diff2,
  output logic [CW+1:0]   diff3,
  output logic [2:0]      neg,
  output logic [CNTW-1:0] result_count
);

  typedef struct packed {
    logic [AW:0] d1;
    logic [CW:0] d2;
  } s1_t;

  s1_t          s1_q;
  s1_t          s1_c;
  logic         s1_vld, s2_vld;
  logic         s2_free, s1_adv, in_hs, out_hs;
  logic [CW+1:0] d3_c;

  // Zero-extend by one bit so the difference carries its own sign.
  assign s1_c.d1 = {1'b0, a} - {1'b0, b};
  assign s1_c.d2 = {1'b0, c} - {1'b0, d};

  // Sign-extend both stage-1 values to CW+2 bits; the range (-270..270 at
  // defaults) always fits, so no overflow handling is needed.
  assign d3_c = {{(CW+1-AW){s1_q.d1[AW]}}, s1_q.d1} - {s1_q.d2[CW], s1_q.d2};

  assign s2_free   = !s2_vld || out_ready;
  assign s1_adv    = s1_vld && s2_free;
  // rst_n gates in_ready so the source never sees a handshake during reset.
  assign in_ready  = rst_n && (!s1_vld || s2_free);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = s2_vld;
  assign out_hs    = s2_vld && out_ready;

  // Stage 1: s1 is only refilled when it is empty or draining this edge,
  // so loading takes priority over clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (in_hs) begin
        s1_q   <= s1_c;
        s1_vld <= 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2: output registers hold their value while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      diff1  <= '0;
      diff2  <= '0;
      diff3  <= '0;
      neg    <= '0;
    end else begin
      if (s1_adv) begin
        s2_vld <= 1'b1;
        diff1  <= s1_q.d1;
        diff2  <= s1_q.d2;
        diff3  <= d3_c;
        neg    <= {d3_c[CW+1], s1_q.d2[CW], s1_q.d1[AW]};
      end else if (out_hs) begin
        s2_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      result_count <= '0;
    else if (out_hs) result_count <= result_count + 1'b1;
  end

endmodule
